// File: rtl/buffered_serializer.sv
// buffered_serializer
//   Word FIFO filled from the fabric and drained as a frame of i_length words.
//   Each word is shifted out over LANES parallel bit lanes, BEATS = DATA_W/LANES
//   beats per word, with no gaps inside a frame. Single clock domain.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_wr_data/i_wr_valid      write side; o_wr_ready = 1 while level < DEPTH
//   i_start/i_length          frame request (sampled only in IDLE), 1..DEPTH words
//   o_start_err               1-cycle pulse: request rejected
//   o_busy                    frame in progress
//   o_ser_data/o_ser_valid    current lane slice and its qualifier
//   o_ser_first/o_ser_last    first / final beat of the frame
//   o_done                    1-cycle pulse on the cycle after o_ser_last
//   o_level                   words currently stored
module buffered_serializer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0,
  parameter int LEN_W     = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_start_err,
  output logic              o_busy,
  output logic [LANES-1:0]  o_ser_data,
  output logic              o_ser_valid,
  output logic              o_ser_first,
  output logic              o_ser_last,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_level
);

  localparam int BEATS = DATA_W / LANES;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]    BEAT_LAST = BW'(BEATS - 1);
  localparam logic [LEN_W-1:0] DEPTH_L   = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LEN_W-1:0]  r_level;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word;
  logic [BW-1:0]     r_beat;
  logic [DATA_W-1:0] r_shreg;
  logic              r_done;
  logic              r_start_err;

  logic              w_wr_en;
  logic              w_len_bad;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_fetch;
  logic              w_shift;
  logic              w_frame_end;
  logic              w_beat_last;
  logic              w_word_last;
  logic [LANES-1:0]  w_slice;
  logic [DATA_W-1:0] w_shreg_nxt;

  assign o_wr_ready = (r_level < DEPTH_L);
  assign w_wr_en    = i_wr_valid && o_wr_ready;

  // Availability is checked against the stored level only; a write landing in
  // the same cycle as the start does not count towards it.
  assign w_len_bad = (i_length == '0) || (i_length > DEPTH_L) || (i_length > r_level);

  assign w_beat_last = (r_beat == BEAT_LAST);
  assign w_word_last = (r_word == (r_len - LEN_W'(1)));

  // Slice selection and shift direction are fixed at elaboration.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_slice     = r_shreg[DATA_W-1 -: LANES];
      assign w_shreg_nxt = r_shreg << LANES;
    end else begin : g_lsb
      assign w_slice     = r_shreg[LANES-1:0];
      assign w_shreg_nxt = r_shreg >> LANES;
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_fetch     = 1'b0;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_len_bad) begin
            w_start_bad = 1'b1;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_beat_last) begin
          if (w_word_last) begin
            w_frame_end = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            // Next word is read on the last beat so the following cycle
            // already carries its beat 0.
            w_fetch = 1'b1;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- storage
  // No reset on the array: a reset discards contents by clearing the pointers.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_beat      <= '0;
      r_shreg     <= '0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_done      <= w_frame_end;
      r_start_err <= w_start_bad;

      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);

      case ({w_wr_en, w_fetch})
        2'b10:   r_level <= r_level + LEN_W'(1);
        2'b01:   r_level <= r_level - LEN_W'(1);
        default: r_level <= r_level;
      endcase

      if (w_start_ok) r_len <= i_length;

      if (w_fetch) begin
        r_shreg  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_beat   <= '0;
        r_word   <= (r_state == S_FETCH) ? '0 : (r_word + LEN_W'(1));
      end else if (w_shift) begin
        r_shreg <= w_shreg_nxt;
        r_beat  <= r_beat + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_busy      = (r_state != S_IDLE);
  assign o_ser_valid = (r_state == S_SHIFT);
  assign o_ser_data  = o_ser_valid ? w_slice : '0;
  assign o_ser_first = o_ser_valid && (r_beat == '0) && (r_word == '0);
  assign o_ser_last  = o_ser_valid && w_beat_last && w_word_last;
  assign o_done      = r_done;
  assign o_start_err = r_start_err;
  assign o_level     = r_level;

endmodule

// File: tb/tb_buffered_serializer.sv
// Bench for buffered_serializer. Instance A (8b, 1 lane, depth 16) is followed
// cycle by cycle by a frame-level model; instances B (4 lanes) and C (2 lanes,
// MSB first) share inputs and are checked against literal beat sequences.
module tb_buffered_serializer;
  localparam int DW  = 8;
  localparam int DA  = 16;
  localparam int LA  = 1;
  localparam int BA  = DW / LA;
  localparam int LW  = $clog2(DA) + 1;
  localparam int DB  = 4;
  localparam int LWB = $clog2(DB) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] a_wd; logic a_wv, a_st; logic [LW-1:0] a_len;
  logic a_wr, a_err, a_busy, a_sv, a_sf, a_sl, a_done;
  logic [LA-1:0] a_sd; logic [LW-1:0] a_lvl;

  logic [7:0] b_wd; logic b_wv, b_st; logic [LWB-1:0] b_len;
  logic b_wr, b_err, b_busy, b_sv, b_sf, b_sl, b_done;
  logic [3:0] b_sd; logic [LWB-1:0] b_lvl;
  logic c_wr, c_err, c_busy, c_sv, c_sf, c_sl, c_done;
  logic [1:0] c_sd; logic [LWB-1:0] c_lvl;

  buffered_serializer #(.DATA_W(DW), .DEPTH(DA), .LANES(LA), .MSB_FIRST(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(a_wd), .i_wr_valid(a_wv), .o_wr_ready(a_wr),
    .i_start(a_st), .i_length(a_len), .o_start_err(a_err), .o_busy(a_busy),
    .o_ser_data(a_sd), .o_ser_valid(a_sv), .o_ser_first(a_sf), .o_ser_last(a_sl),
    .o_done(a_done), .o_level(a_lvl));

  buffered_serializer #(.DATA_W(DW), .DEPTH(DB), .LANES(4), .MSB_FIRST(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(b_wd), .i_wr_valid(b_wv), .o_wr_ready(b_wr),
    .i_start(b_st), .i_length(b_len), .o_start_err(b_err), .o_busy(b_busy),
    .o_ser_data(b_sd), .o_ser_valid(b_sv), .o_ser_first(b_sf), .o_ser_last(b_sl),
    .o_done(b_done), .o_level(b_lvl));

  buffered_serializer #(.DATA_W(DW), .DEPTH(DB), .LANES(2), .MSB_FIRST(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(b_wd), .i_wr_valid(b_wv), .o_wr_ready(c_wr),
    .i_start(b_st), .i_length(b_len), .o_start_err(c_err), .o_busy(c_busy),
    .o_ser_data(c_sd), .o_ser_valid(c_sv), .o_ser_first(c_sf), .o_ser_last(c_sl),
    .o_done(c_done), .o_level(c_lvl));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ model (A)
  // Frame tracked as edges elapsed since the accepting edge: edge e>=1
  // presents frame beat e-1; a word is taken from the queue on every edge
  // that begins a word; edge len*BEATS+1 closes the frame with done.
  logic [7:0] mq[$];
  bit         m_act, e_done, e_err, m_ok;
  int         m_e, m_len;
  logic [7:0] m_cur;
  initial m_ok = 1'b0;

  always @(posedge clk) begin : model
    int lvl0;
    bit idle0;
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_e = 0; m_len = 0; m_cur = '0; e_done = 0; e_err = 0; m_ok = 1;
    end else begin
      lvl0  = mq.size();
      idle0 = !m_act;
      e_done = 0;
      e_err  = 0;
      if (m_act) begin
        m_e++;
        if (m_e == m_len * BA + 1) begin
          m_act  = 0;
          e_done = 1;
        end else if ((m_e - 1) % BA == 0 && mq.size() > 0) begin
          m_cur = mq.pop_front();
        end
      end
      if (a_wv && lvl0 < DA) mq.push_back(a_wd);
      if (idle0 && a_st) begin
        if (a_len == 0 || a_len > DA || a_len > lvl0) e_err = 1;
        else begin m_act = 1; m_e = 0; m_len = int'(a_len); end
      end
    end
  end

  always @(negedge clk) begin : compare
    int j;
    bit ev;
    logic [LA-1:0] ed;
    logic [7+LA+LW-1:0] got, exp;
    if (m_ok) begin
      ev  = m_act && (m_e >= 1);
      j   = m_e - 1;
      ed  = ev ? LA'(m_cur >> ((j % BA) * LA)) : '0;
      got = {a_wr, a_busy, a_sv, a_sf, a_sl, a_done, a_err, a_sd, a_lvl};
      exp = {mq.size() < DA, m_act, ev, ev && (j == 0), ev && (j == m_len * BA - 1),
             e_done, e_err, ed, LW'(mq.size())};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t: got rdy/busy/v/f/l/done/err=%b%b%b%b%b%b%b d=%h lvl=%0d, expected %b%b%b%b%b%b%b d=%h lvl=%0d",
                 $time, a_wr, a_busy, a_sv, a_sf, a_sl, a_done, a_err, a_sd, a_lvl,
                 exp[6+LA+LW], exp[5+LA+LW], exp[4+LA+LW], exp[3+LA+LW], exp[2+LA+LW],
                 exp[1+LA+LW], exp[LA+LW], ed, mq.size());
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_write(input logic [7:0] d);
    a_wv = 1'b1; a_wd = d; tick(); a_wv = 1'b0;
  endtask

  task automatic a_start(input int len);
    a_st = 1'b1; a_len = LW'(len); tick(); a_st = 1'b0;
  endtask

  task automatic wait_a_done(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (a_done) seen = 1;
    end
    chk("a_done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_a_idle(input int bound);
    for (int i = 0; i < bound && a_busy; i++) tick();
    chk("a_idle_timeout", 64'(a_busy), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    logic [7:0]  bits, fv, lv;
    logic [15:0] colb, colc;
    rst_n = 1'b0;
    a_wd = '0; a_wv = 0; a_st = 0; a_len = '0;
    b_wd = '0; b_wv = 0; b_st = 0; b_len = '0;
    @(negedge clk);
    repeat (3) tick();
    chk("reset_wr_ready", 64'(a_wr), 64'd1);
    chk("reset_level",    64'(a_lvl), 64'd0);
    chk("reset_busy",     64'({a_busy, a_sv, a_done, a_err}), 64'd0);
    chk("reset_b_ready",  64'({b_wr, c_wr}), 64'b11);
    rst_n = 1'b1;
    tick();

    // 1: 0xA5 single lane LSB first
    a_write(8'hA5);
    a_start(1);
    chk("t1_k1_busy_novalid", 64'({a_busy, a_sv}), 64'b10);
    bits = '0; fv = '0; lv = '0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      bits = {bits[6:0], a_sd};
      fv   = {fv[6:0], a_sf};
      lv   = {lv[6:0], a_sl};
    end
    chk("t1_bits",  64'(bits), 64'b10100101);
    chk("t1_first", 64'(fv),   64'b10000000);
    chk("t1_last",  64'(lv),   64'b00000001);
    tick();
    chk("t1_done_k10", 64'({a_done, a_busy}), 64'b10);

    // 2: 4 lanes LSB first (B) and 2 lanes MSB first (C)
    b_wv = 1; b_wd = 8'h3C; tick(); b_wd = 8'h81; tick(); b_wv = 0;
    chk("t2_level_before", 64'(b_lvl), 64'd2);
    b_st = 1; b_len = LWB'(2); tick(); b_st = 0;
    colb = '0; colc = '0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (k <= 5) colb = {colb[11:0], b_sd};
      if (k <= 9) colc = {colc[13:0], c_sd};
      if (k == 6)  chk("t2_b_done", 64'({b_done, b_busy}), 64'b10);
      if (k == 10) chk("t2_c_done", 64'({c_done, c_busy}), 64'b10);
    end
    chk("t2_b_beats", 64'(colb), 64'hC318);
    chk("t2_c_beats", 64'(colc), 64'h3C81);
    chk("t2_level_after", 64'({b_lvl, c_lvl}), 64'd0);

    // 4: rejected starts and start while busy
    a_write(8'h11);
    a_write(8'h22);
    a_start(3);
    chk("t4_err_len_gt_level", 64'({a_err, a_sv}), 64'b10);
    tick();
    a_start(0);
    chk("t4_err_len0", 64'(a_err), 64'd1);
    a_start(2);
    tick(); tick();
    a_start(1);
    chk("t4_busy_start_no_err", 64'({a_err, a_busy}), 64'b01);
    wait_a_done(40);

    // 3: fill to DEPTH (pointers already offset, so the frame wraps)
    a_wv = 1;
    for (int i = 0; i < DA + 1; i++) begin
      a_wd = 8'(8'h40 + i);
      tick();
    end
    a_wv = 0;
    chk("t3_full_level", 64'(a_lvl), 64'(DA));
    chk("t3_full_ready", 64'(a_wr), 64'd0);
    a_start(DA);
    wait_a_done(DA * BA + 20);
    chk("t3_drained", 64'(a_lvl), 64'd0);

    // 5: writes during a frame, start on the done cycle
    for (int i = 0; i < 4; i++) a_write(8'($urandom));
    a_start(2);
    a_wv = 1;
    begin : t5_wait
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        a_wd = 8'($urandom);
        tick();
        if (a_done) seen = 1;
      end
      chk("t5_done_seen", 64'(seen), 64'd1);
    end
    a_st = 1; a_len = LW'(2); tick(); a_st = 0; a_wv = 0;
    chk("t5_b2b_busy", 64'({a_busy, a_sv}), 64'b10);
    tick();
    chk("t5_gap_k2_valid", 64'(a_sv), 64'd1);
    wait_a_done(40);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      a_wv  = ($urandom_range(0, (i < 1500) ? 2 : 9) == 0);
      a_wd  = 8'($urandom);
      a_st  = ($urandom_range(0, 7) == 0) || a_done;
      a_len = LW'($urandom_range(0, DA + 2));
      tick();
    end
    a_wv = 0; a_st = 0;
    wait_a_idle(DA * BA + 20);

    // 6: reset mid-frame at beat 5
    a_write(8'h5A);
    a_start(1);
    for (int k = 2; k <= 7; k++) tick();
    chk("t6_beat5_valid", 64'(a_sv), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_reset_outputs", 64'({a_busy, a_sv, a_sf, a_sl, a_done, a_err, a_sd}), 64'd0);
    chk("t6_reset_level", 64'(a_lvl), 64'd0);
    rst_n = 1'b1;
    a_write(8'h96);
    a_start(1);
    wait_a_done(20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
